// File: rtl/rt_ibex_hws_sched_pkg.sv
// Shared types and default sizes for the RT-Ibex hardware-stacking scheduler.
// Contents: stacking mode (SAVE/RESTORE), scheduler FSM state encoding,
// default nesting depth / priority / irq id widths.
package rt_ibex_hws_sched_pkg;

   localparam int unsigned HwsMaxNest = 4;
   localparam int unsigned HwsPrioW   = 3;
   localparam int unsigned HwsIrqIdW  = 5;

   typedef enum logic {
      HWS_SAVE    = 1'b0,
      HWS_RESTORE = 1'b1
   } hw_stacking_mode_t;

   typedef enum logic [2:0] {
      HWS_IDLE         = 3'd0,
      HWS_SAVE_REQ     = 3'd1,
      HWS_SAVE_WAIT    = 3'd2,
      HWS_RUN          = 3'd3,
      HWS_RESTORE_REQ  = 3'd4,
      HWS_RESTORE_WAIT = 3'd5
   } hws_sched_state_e;

endpackage

// File: rtl/rt_ibex_hws_sched_prio.sv
// rt_ibex_prio_stack: LIFO of saved running priorities, one entry per active
// handler level. top/depth/full are registered copies kept in step with the
// entry array so the scheduler sees them without a read mux.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset (empties the stack)
//   push_i          push push_data_i (ignored when full)
//   push_data_i     priority to save
//   pop_i           drop the top entry (ignored when empty)
//   top_o           most recently pushed priority (0 when empty)
//   depth_o         number of stored entries
//   full_o          depth_o == MaxNest
module rt_ibex_prio_stack
   import rt_ibex_hws_sched_pkg::*;
#(
   parameter int unsigned MaxNest = HwsMaxNest,
   parameter int unsigned PrioW   = HwsPrioW,
   localparam int unsigned DepthW = $clog2(MaxNest + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [PrioW-1:0]  push_data_i,
   input  logic              pop_i,
   output logic [PrioW-1:0]  top_o,
   output logic [DepthW-1:0] depth_o,
   output logic              full_o
);

   localparam int unsigned IdxW = (MaxNest > 1) ? $clog2(MaxNest) : 1;

   logic [PrioW-1:0]  mem_q [MaxNest];
   logic [PrioW-1:0]  top_q;
   logic [DepthW-1:0] depth_q;
   logic              full_q;

   // Entry array plus registered top/depth/full.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(MaxNest); i++) begin
            mem_q[i] <= '0;
         end
         top_q   <= '0;
         depth_q <= '0;
         full_q  <= 1'b0;
      end else if (push_i && !full_q) begin
         mem_q[IdxW'(depth_q)] <= push_data_i;
         top_q                 <= push_data_i;
         depth_q               <= depth_q + DepthW'(1);
         full_q                <= (depth_q == DepthW'(MaxNest - 1));
      end else if (pop_i && (depth_q != '0)) begin
         depth_q <= depth_q - DepthW'(1);
         full_q  <= 1'b0;
         // New top is the entry below the one being dropped.
         top_q   <= (depth_q >= DepthW'(2)) ? mem_q[IdxW'(depth_q - DepthW'(2))] : '0;
      end
   end

   assign top_o   = top_q;
   assign depth_o = depth_q;
   assign full_o  = full_q;

endmodule

// File: rtl/rt_ibex_hws_sched.sv
// rt_ibex_hws_sched: interrupt entry/exit scheduler for the RT-Ibex hardware
// stacking unit. Starts a context SAVE when an irq preempts the running
// priority and a RESTORE when mret is reached, runs the start/done/ack
// handshake, tracks nesting on a priority stack and halts the core while
// stacking is in progress.
// Optional feature: define RT_IBEX_HWS_TAIL_CHAIN_EN to let an mret with a
// higher-than-stack-top irq pending jump straight to the new handler, reusing
// the saved frame. Without it tail_chain_o is 0 and every mret restores.
// Ports:
//   clk_i, rst_ni                clock, async active-low reset
//   irq_req_i/irq_id_i/irq_prio_i pending interrupt (level), id, priority
//   mret_id_i                    mret in ID, held until mret_ack_o
//   hws_start_o/hws_mode_o       start pulse and SAVE/RESTORE mode
//   hws_done_i/hws_ack_o         stacking done level and its ack pulse
//   irq_ack_o/irq_ack_id_o       claim pulse and claimed id
//   mret_ack_o/tail_chain_o      mret may retire / retire into new vector
//   core_halt_o                  hold fetch/controller while stacking
//   cur_prio_o/nest_depth_o      running priority and active handler levels
module rt_ibex_hws_sched
   import rt_ibex_hws_sched_pkg::*;
#(
   parameter int unsigned MaxNest = HwsMaxNest,
   parameter int unsigned PrioW   = HwsPrioW,
   parameter int unsigned IrqIdW  = HwsIrqIdW,
   localparam int unsigned DepthW = $clog2(MaxNest + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              irq_req_i,
   input  logic [IrqIdW-1:0] irq_id_i,
   input  logic [PrioW-1:0]  irq_prio_i,
   input  logic              mret_id_i,
   output logic              hws_start_o,
   output hw_stacking_mode_t hws_mode_o,
   input  logic              hws_done_i,
   output logic              hws_ack_o,
   output logic              irq_ack_o,
   output logic [IrqIdW-1:0] irq_ack_id_o,
   output logic              mret_ack_o,
   output logic              tail_chain_o,
   output logic              core_halt_o,
   output logic [PrioW-1:0]  cur_prio_o,
   output logic [DepthW-1:0] nest_depth_o
);

   hws_sched_state_e  state_q;
   hw_stacking_mode_t mode_q;
   logic              hws_start_q;
   logic              hws_ack_q;
   logic              irq_ack_q;
   logic [IrqIdW-1:0] irq_ack_id_q;
   logic              mret_ack_q;
   logic              halt_q;
   logic [PrioW-1:0]  cur_prio_q;
   logic [DepthW-1:0] depth_q;
   logic [IrqIdW-1:0] cap_id_q;
   logic [PrioW-1:0]  cap_prio_q;

   logic              stk_push;
   logic              stk_pop;
   logic [PrioW-1:0]  stk_top;
   logic [DepthW-1:0] stk_depth;
   logic              stk_full;

   logic              mret_req;
   logic              preempt;
   logic              tail_hit;

   // The core keeps mret_id_i high during the ack cycle; ignore it there so
   // one mret is never acknowledged twice.
   assign mret_req = mret_id_i && !mret_ack_q;
   assign preempt  = irq_req_i && (irq_prio_i > cur_prio_q) && !stk_full;

`ifdef RT_IBEX_HWS_TAIL_CHAIN_EN
   assign tail_hit = irq_req_i && (irq_prio_i > stk_top);
`else
   assign tail_hit = 1'b0;
`endif

   assign stk_push = ((state_q == HWS_IDLE) || (state_q == HWS_RUN)) && !mret_req && preempt;
   assign stk_pop  = (state_q == HWS_RESTORE_WAIT) && hws_done_i;

   rt_ibex_prio_stack #(
      .MaxNest (MaxNest),
      .PrioW   (PrioW)
   ) u_prio_stack (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (stk_push),
      .push_data_i (cur_prio_q),
      .pop_i       (stk_pop),
      .top_o       (stk_top),
      .depth_o     (stk_depth),
      .full_o      (stk_full)
   );

   // Scheduler FSM with registered handshake outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= HWS_IDLE;
         mode_q       <= HWS_SAVE;
         hws_start_q  <= 1'b0;
         hws_ack_q    <= 1'b0;
         irq_ack_q    <= 1'b0;
         irq_ack_id_q <= '0;
         mret_ack_q   <= 1'b0;
         halt_q       <= 1'b0;
         cur_prio_q   <= '0;
         depth_q      <= '0;
         cap_id_q     <= '0;
         cap_prio_q   <= '0;
      end else begin
         hws_start_q <= 1'b0;
         hws_ack_q   <= 1'b0;
         irq_ack_q   <= 1'b0;
         mret_ack_q  <= 1'b0;
         unique case (state_q)
            HWS_IDLE: begin
               if (mret_req) begin
                  // Nothing to restore at thread level.
                  mret_ack_q <= 1'b1;
               end else if (preempt) begin
                  cap_id_q   <= irq_id_i;
                  cap_prio_q <= irq_prio_i;
                  mode_q     <= HWS_SAVE;
                  halt_q     <= 1'b1;
                  state_q    <= HWS_SAVE_REQ;
               end
            end
            HWS_SAVE_REQ: begin
               hws_start_q  <= 1'b1;
               irq_ack_q    <= 1'b1;
               irq_ack_id_q <= cap_id_q;
               state_q      <= HWS_SAVE_WAIT;
            end
            HWS_SAVE_WAIT: begin
               if (hws_done_i) begin
                  hws_ack_q  <= 1'b1;
                  depth_q    <= depth_q + DepthW'(1);
                  cur_prio_q <= cap_prio_q;
                  halt_q     <= 1'b0;
                  state_q    <= HWS_RUN;
               end
            end
            HWS_RUN: begin
               if (mret_req && tail_hit) begin
                  // Saved frame stays on the stack; enter the new handler directly.
                  mret_ack_q   <= 1'b1;
                  irq_ack_q    <= 1'b1;
                  irq_ack_id_q <= irq_id_i;
                  cur_prio_q   <= irq_prio_i;
               end else if (mret_req) begin
                  mode_q  <= HWS_RESTORE;
                  halt_q  <= 1'b1;
                  state_q <= HWS_RESTORE_REQ;
               end else if (preempt) begin
                  cap_id_q   <= irq_id_i;
                  cap_prio_q <= irq_prio_i;
                  mode_q     <= HWS_SAVE;
                  halt_q     <= 1'b1;
                  state_q    <= HWS_SAVE_REQ;
               end
            end
            HWS_RESTORE_REQ: begin
               hws_start_q <= 1'b1;
               state_q     <= HWS_RESTORE_WAIT;
            end
            HWS_RESTORE_WAIT: begin
               if (hws_done_i) begin
                  hws_ack_q  <= 1'b1;
                  mret_ack_q <= 1'b1;
                  cur_prio_q <= stk_top;
                  depth_q    <= depth_q - DepthW'(1);
                  halt_q     <= 1'b0;
                  // The entry being popped is the last one: back to thread level.
                  state_q    <= (stk_depth == DepthW'(1)) ? HWS_IDLE : HWS_RUN;
               end
            end
            default: begin
               halt_q  <= 1'b0;
               state_q <= HWS_IDLE;
            end
         endcase
      end
   end

`ifdef RT_IBEX_HWS_TAIL_CHAIN_EN
   logic tail_chain_q;

   // Flags the mret ack that retires into the newly claimed vector.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tail_chain_q <= 1'b0;
      end else begin
         tail_chain_q <= (state_q == HWS_RUN) && mret_req && tail_hit;
      end
   end

   assign tail_chain_o = tail_chain_q;
`else
   assign tail_chain_o = 1'b0;
`endif

   assign hws_start_o  = hws_start_q;
   assign hws_mode_o   = mode_q;
   assign hws_ack_o    = hws_ack_q;
   assign irq_ack_o    = irq_ack_q;
   assign irq_ack_id_o = irq_ack_id_q;
   assign mret_ack_o   = mret_ack_q;
   assign core_halt_o  = halt_q;
   assign cur_prio_o   = cur_prio_q;
   assign nest_depth_o = depth_q;

endmodule

// File: tb/tb_rt_ibex_hws_sched.sv
// Self-checking bench for rt_ibex_hws_sched: a cycle-by-cycle vector table
// for save/nest/restore, then directed sequences for nesting limit,
// mret+irq collision (or tail chaining when RT_IBEX_HWS_TAIL_CHAIN_EN is
// defined) and reset during stacking.
module tb_rt_ibex_hws_sched;
   import rt_ibex_hws_sched_pkg::*;

   localparam int unsigned MaxNest = 4;
   localparam int unsigned PrioW   = 3;
   localparam int unsigned IrqIdW  = 5;
   localparam int unsigned DepthW  = 3;

   logic              clk_i;
   logic              rst_ni;
   logic              irq_req_i;
   logic [IrqIdW-1:0] irq_id_i;
   logic [PrioW-1:0]  irq_prio_i;
   logic              mret_id_i;
   logic              hws_start_o;
   hw_stacking_mode_t hws_mode_o;
   logic              hws_done_i;
   logic              hws_ack_o;
   logic              irq_ack_o;
   logic [IrqIdW-1:0] irq_ack_id_o;
   logic              mret_ack_o;
   logic              tail_chain_o;
   logic              core_halt_o;
   logic [PrioW-1:0]  cur_prio_o;
   logic [DepthW-1:0] nest_depth_o;

   int n_cmp = 0;
   int n_bad = 0;

   rt_ibex_hws_sched #(
      .MaxNest (MaxNest),
      .PrioW   (PrioW),
      .IrqIdW  (IrqIdW)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .irq_req_i    (irq_req_i),
      .irq_id_i     (irq_id_i),
      .irq_prio_i   (irq_prio_i),
      .mret_id_i    (mret_id_i),
      .hws_start_o  (hws_start_o),
      .hws_mode_o   (hws_mode_o),
      .hws_done_i   (hws_done_i),
      .hws_ack_o    (hws_ack_o),
      .irq_ack_o    (irq_ack_o),
      .irq_ack_id_o (irq_ack_id_o),
      .mret_ack_o   (mret_ack_o),
      .tail_chain_o (tail_chain_o),
      .core_halt_o  (core_halt_o),
      .cur_prio_o   (cur_prio_o),
      .nest_depth_o (nest_depth_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic              req;
      logic [IrqIdW-1:0] id;
      logic [PrioW-1:0]  prio;
      logic              mret;
      logic              done;
      logic              start;
      hw_stacking_mode_t mode;
      logic              hack;
      logic              iack;
      logic [IrqIdW-1:0] iid;
      logic              mack;
      logic              halt;
      logic [PrioW-1:0]  cprio;
      logic [DepthW-1:0] depth;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int req, int id, int prio, int mret, int done,
                               int start, int mode, int hack, int iack, int iid,
                               int mack, int halt, int cprio, int depth);
      vec_t v;
      v.req   = 1'(req);
      v.id    = IrqIdW'(id);
      v.prio  = PrioW'(prio);
      v.mret  = 1'(mret);
      v.done  = 1'(done);
      v.start = 1'(start);
      v.mode  = hw_stacking_mode_t'(1'(mode));
      v.hack  = 1'(hack);
      v.iack  = 1'(iack);
      v.iid   = IrqIdW'(iid);
      v.mack  = 1'(mack);
      v.halt  = 1'(halt);
      v.cprio = PrioW'(cprio);
      v.depth = DepthW'(depth);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Take an irq from IDLE/RUN through SAVE; done arrives gap cycles after start.
   task automatic do_save(input int id, input int prio, input int gap, input int exp_depth);
      int lat;
      lat = 0;
      irq_req_i  = 1'b1;
      irq_id_i   = IrqIdW'(id);
      irq_prio_i = PrioW'(prio);
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         step();
         if (hws_start_o) lat = c;
      end
      chk("save_start_latency", lat, 2);
      chk("save_mode", int'(hws_mode_o), int'(HWS_SAVE));
      chk("save_irq_ack", int'(irq_ack_o), 1);
      chk("save_irq_ack_id", int'(irq_ack_id_o), id);
      chk("save_halt", int'(core_halt_o), 1);
      irq_req_i = 1'b0;
      repeat (gap) step();
      chk("save_wait_halt", int'(core_halt_o), 1);
      chk("save_wait_depth", int'(nest_depth_o), exp_depth - 1);
      hws_done_i = 1'b1;
      step();
      chk("save_hws_ack", int'(hws_ack_o), 1);
      chk("save_cur_prio", int'(cur_prio_o), prio);
      chk("save_depth", int'(nest_depth_o), exp_depth);
      chk("save_halt_release", int'(core_halt_o), 0);
      hws_done_i = 1'b0;
      step();
      chk("save_hws_ack_pulse", int'(hws_ack_o), 0);
   endtask

   // mret from RUN through RESTORE.
   task automatic do_restore(input int exp_prio, input int exp_depth);
      int lat;
      lat = 0;
      mret_id_i = 1'b1;
      for (int c = 1; c <= 10 && lat == 0; c++) begin
         step();
         if (hws_start_o) lat = c;
      end
      chk("restore_start_latency", lat, 2);
      chk("restore_mode", int'(hws_mode_o), int'(HWS_RESTORE));
      chk("restore_halt", int'(core_halt_o), 1);
      chk("restore_no_early_mret_ack", int'(mret_ack_o), 0);
      step();
      hws_done_i = 1'b1;
      step();
      chk("restore_hws_ack", int'(hws_ack_o), 1);
      chk("restore_mret_ack", int'(mret_ack_o), 1);
      chk("restore_tail_chain", int'(tail_chain_o), 0);
      chk("restore_cur_prio", int'(cur_prio_o), exp_prio);
      chk("restore_depth", int'(nest_depth_o), exp_depth);
      chk("restore_halt_release", int'(core_halt_o), 0);
      mret_id_i  = 1'b0;
      hws_done_i = 1'b0;
      step();
      chk("restore_mret_ack_pulse", int'(mret_ack_o), 0);
      chk("restore_hws_ack_pulse", int'(hws_ack_o), 0);
   endtask

   initial begin
      localparam int S = 0;
      localparam int R = 1;

      rst_ni     = 1'b0;
      irq_req_i  = 1'b0;
      irq_id_i   = '0;
      irq_prio_i = '0;
      mret_id_i  = 1'b0;
      hws_done_i = 1'b0;

      // Cycle-by-cycle: single save, nested save, equal-priority irq, two
      // restores, mret at thread level.
      //            req id pr mr dn  st md hk ia iid mk ht cp dp
      vecs.push_back(mk(1, 7, 2, 0, 0,  0, S, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 7, 2, 0, 0,  1, S, 0, 1, 7, 0, 1, 0, 0));
      vecs.push_back(mk(1, 4, 6, 0, 0,  0, S, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1,  0, S, 1, 0, 0, 0, 0, 2, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, S, 0, 0, 0, 0, 0, 2, 1));
      vecs.push_back(mk(1, 9, 5, 0, 0,  0, S, 0, 0, 0, 0, 1, 2, 1));
      vecs.push_back(mk(1, 9, 5, 0, 0,  1, S, 0, 1, 9, 0, 1, 2, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1,  0, S, 1, 0, 0, 0, 0, 5, 2));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, S, 0, 0, 0, 0, 0, 5, 2));
      vecs.push_back(mk(1, 3, 5, 0, 0,  0, S, 0, 0, 0, 0, 0, 5, 2));
      vecs.push_back(mk(1, 3, 5, 0, 0,  0, S, 0, 0, 0, 0, 0, 5, 2));
      vecs.push_back(mk(0, 0, 0, 1, 0,  0, R, 0, 0, 0, 0, 1, 5, 2));
      vecs.push_back(mk(0, 0, 0, 1, 0,  1, R, 0, 0, 0, 0, 1, 5, 2));
      vecs.push_back(mk(0, 0, 0, 1, 1,  0, R, 1, 0, 0, 1, 0, 2, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, R, 0, 0, 0, 0, 0, 2, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0,  0, R, 0, 0, 0, 0, 1, 2, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0,  1, R, 0, 0, 0, 0, 1, 2, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1,  0, R, 1, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, R, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0,  0, R, 0, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0, R, 0, 0, 0, 0, 0, 0, 0));

      #1;
      chk("reset_start", int'(hws_start_o), 0);
      chk("reset_mode", int'(hws_mode_o), int'(HWS_SAVE));
      chk("reset_halt", int'(core_halt_o), 0);
      chk("reset_prio", int'(cur_prio_o), 0);
      chk("reset_depth", int'(nest_depth_o), 0);
      chk("reset_irq_ack", int'(irq_ack_o), 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();

      for (int i = 0; i < vecs.size(); i++) begin
         irq_req_i  = vecs[i].req;
         irq_id_i   = vecs[i].id;
         irq_prio_i = vecs[i].prio;
         mret_id_i  = vecs[i].mret;
         hws_done_i = vecs[i].done;
         step();
         chk($sformatf("v%0d.start", i), int'(hws_start_o), int'(vecs[i].start));
         chk($sformatf("v%0d.mode", i), int'(hws_mode_o), int'(vecs[i].mode));
         chk($sformatf("v%0d.hws_ack", i), int'(hws_ack_o), int'(vecs[i].hack));
         chk($sformatf("v%0d.irq_ack", i), int'(irq_ack_o), int'(vecs[i].iack));
         if (vecs[i].iack)
            chk($sformatf("v%0d.irq_ack_id", i), int'(irq_ack_id_o), int'(vecs[i].iid));
         chk($sformatf("v%0d.mret_ack", i), int'(mret_ack_o), int'(vecs[i].mack));
         chk($sformatf("v%0d.tail_chain", i), int'(tail_chain_o), 0);
         chk($sformatf("v%0d.halt", i), int'(core_halt_o), int'(vecs[i].halt));
         chk($sformatf("v%0d.cur_prio", i), int'(cur_prio_o), int'(vecs[i].cprio));
         chk($sformatf("v%0d.depth", i), int'(nest_depth_o), int'(vecs[i].depth));
      end
      irq_req_i = 1'b0;
      mret_id_i = 1'b0;
      hws_done_i = 1'b0;

      // Single irq with the stacking unit taking 20 cycles.
      do_save(7, 2, 20, 1);
      do_restore(0, 0);

      // Fill to MaxNest; a prio-7 irq must then be blocked.
      do_save(1, 1, 2, 1);
      do_save(2, 2, 2, 2);
      do_save(3, 3, 2, 3);
      do_save(4, 4, 2, 4);
      irq_req_i  = 1'b1;
      irq_id_i   = 5'd30;
      irq_prio_i = 3'd7;
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("full_no_start%0d", c), int'(hws_start_o), 0);
         chk($sformatf("full_no_irq_ack%0d", c), int'(irq_ack_o), 0);
         chk($sformatf("full_no_halt%0d", c), int'(core_halt_o), 0);
      end
      irq_req_i = 1'b0;
      do_restore(3, 3);
      do_restore(2, 2);
      do_restore(1, 1);
      do_restore(0, 0);

      do_save(5, 2, 2, 1);
`ifdef RT_IBEX_HWS_TAIL_CHAIN_EN
      // mret with a prio-3 irq pending above stack top 0: chain directly.
      mret_id_i  = 1'b1;
      irq_req_i  = 1'b1;
      irq_id_i   = 5'd10;
      irq_prio_i = 3'd3;
      step();
      chk("tc_no_start", int'(hws_start_o), 0);
      chk("tc_mret_ack", int'(mret_ack_o), 1);
      chk("tc_tail_chain", int'(tail_chain_o), 1);
      chk("tc_irq_ack", int'(irq_ack_o), 1);
      chk("tc_irq_ack_id", int'(irq_ack_id_o), 10);
      chk("tc_prio", int'(cur_prio_o), 3);
      chk("tc_depth", int'(nest_depth_o), 1);
      chk("tc_halt", int'(core_halt_o), 0);
      mret_id_i = 1'b0;
      irq_req_i = 1'b0;
      step();
      chk("tc_pulse_end", int'(tail_chain_o), 0);
      chk("tc_no_start2", int'(hws_start_o), 0);
      do_restore(0, 0);
`else
      // mret and a prio-1 irq together: restore first, then save from IDLE.
      mret_id_i  = 1'b1;
      irq_req_i  = 1'b1;
      irq_id_i   = 5'd6;
      irq_prio_i = 3'd1;
      step();
      chk("col_halt", int'(core_halt_o), 1);
      chk("col_mode", int'(hws_mode_o), int'(HWS_RESTORE));
      step();
      chk("col_restore_start", int'(hws_start_o), 1);
      chk("col_restore_mode", int'(hws_mode_o), int'(HWS_RESTORE));
      chk("col_no_irq_ack", int'(irq_ack_o), 0);
      hws_done_i = 1'b1;
      step();
      chk("col_mret_ack", int'(mret_ack_o), 1);
      chk("col_tail_chain", int'(tail_chain_o), 0);
      chk("col_prio0", int'(cur_prio_o), 0);
      chk("col_depth0", int'(nest_depth_o), 0);
      mret_id_i  = 1'b0;
      hws_done_i = 1'b0;
      step();
      chk("col_save_halt", int'(core_halt_o), 1);
      chk("col_save_mode", int'(hws_mode_o), int'(HWS_SAVE));
      step();
      chk("col_save_start", int'(hws_start_o), 1);
      chk("col_irq_ack", int'(irq_ack_o), 1);
      chk("col_irq_ack_id", int'(irq_ack_id_o), 6);
      irq_req_i = 1'b0;
      step();
      hws_done_i = 1'b1;
      step();
      chk("col_save_ack", int'(hws_ack_o), 1);
      chk("col_prio1", int'(cur_prio_o), 1);
      chk("col_depth1", int'(nest_depth_o), 1);
      hws_done_i = 1'b0;
      step();
      do_restore(0, 0);
`endif

      // Reset while waiting for SAVE to finish; the stale done must not be acked.
      irq_req_i  = 1'b1;
      irq_id_i   = 5'd12;
      irq_prio_i = 3'd4;
      step();
      step();
      chk("rst_seq_start", int'(hws_start_o), 1);
      irq_req_i = 1'b0;
      step();
      hws_done_i = 1'b1;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("rst_async_halt", int'(core_halt_o), 0);
      chk("rst_async_depth", int'(nest_depth_o), 0);
      chk("rst_async_prio", int'(cur_prio_o), 0);
      chk("rst_async_start", int'(hws_start_o), 0);
      chk("rst_async_irq_ack", int'(irq_ack_o), 0);
      chk("rst_async_mode", int'(hws_mode_o), int'(HWS_SAVE));
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("rst_stale_no_ack%0d", c), int'(hws_ack_o), 0);
         chk($sformatf("rst_stale_no_halt%0d", c), int'(core_halt_o), 0);
         chk($sformatf("rst_stale_no_mret_ack%0d", c), int'(mret_ack_o), 0);
      end
      hws_done_i = 1'b0;
      step();
      do_save(13, 3, 2, 1);
      do_restore(0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rt_ibex_hws_sched.md
Name: rt_ibex_hws_sched

Overview:
- Interrupt-entry/exit scheduler that sequences the RT-Ibex hardware stacking unit.
- Decides when to start a context SAVE (irq accepted) or RESTORE (mret reached), and completes the start/done/ack handshake.
- Tracks preemption nesting with a priority stack and halts the core controller while stacking runs.
- Sits between the interrupt controller, ibex_controller and the hardware stacking unit.

Parameters:
- MaxNest, 4, maximum nesting depth; stack entries hold saved priorities.
- PrioW, 3, interrupt priority width.
- IrqIdW, 5, interrupt id width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- irq_req_i  in  1  an interrupt is pending (level).
- irq_id_i  in  IrqIdW  id of the pending interrupt.
- irq_prio_i  in  PrioW  priority of the pending interrupt.
- mret_id_i  in  1  mret decoded in ID; core waits for mret_ack_o.
- hws_start_o  out  1  one-cycle start pulse to the stacking unit.
- hws_mode_o  out  hw_stacking_mode_t  SAVE/RESTORE; stable from start until ack.
- hws_done_i  in  1  stacking unit finished (registered level).
- hws_ack_o  out  1  one-cycle acknowledge of done.
- irq_ack_o  out  1  one-cycle claim pulse to the interrupt controller.
- irq_ack_id_o  out  IrqIdW  claimed id, valid with irq_ack_o.
- mret_ack_o  out  1  one-cycle pulse; mret may complete.
- tail_chain_o  out  1  with mret_ack_o: jump to the new vector instead of mepc.
- core_halt_o  out  1  hold fetch/controller during stacking.
- cur_prio_o  out  PrioW  current running priority; 0 = thread level.
- nest_depth_o  out  $clog2(MaxNest+1)  number of active handler levels.

Behaviour:
- All outputs are registered. Reset values: all pulses 0, hws_mode_o=SAVE, cur_prio_o=0, nest_depth_o=0, core_halt_o=0, FSM=IDLE.
- Preemption condition (preempt): irq_req_i && irq_prio_i > cur_prio && depth < MaxNest.
- FSM states: IDLE, SAVE_REQ, SAVE_WAIT, RUN, RESTORE_REQ, RESTORE_WAIT.
- IDLE/RUN with preempt (and no mret in RUN):
  - capture id and priority;
  - push cur_prio onto the stack;
  - go to SAVE_REQ.
- SAVE_REQ:
  - pulse hws_start_o with mode SAVE;
  - pulse irq_ack_o with the captured id;
  - go to SAVE_WAIT.
- SAVE_WAIT, when hws_done_i:
  - pulse hws_ack_o;
  - depth++, cur_prio <= captured priority;
  - go to RUN.
- RUN with mret_id_i and no tail chain: go to RESTORE_REQ. This path wins over a simultaneous irq.
- RESTORE_REQ: pulse hws_start_o with mode RESTORE; go to RESTORE_WAIT.
- RESTORE_WAIT, when hws_done_i:
  - pulse hws_ack_o and mret_ack_o;
  - pop the stack into cur_prio, depth--;
  - go to IDLE if the new depth is 0, else RUN.
- core_halt_o is 1 in SAVE_REQ, SAVE_WAIT, RESTORE_REQ and RESTORE_WAIT; 0 otherwise.
- Latency:
  - preempt to hws_start_o is 2 cycles;
  - hws_done_i to hws_ack_o is 1 cycle.
  - hws_done_i must stay high until ack; done deasserting before ack is ignored.
- Boundaries:
  - irqs arriving in the *_REQ/*_WAIT states are ignored and stay pending.
  - Equal priority does not preempt.
  - depth==MaxNest blocks all preemption.
  - mret_id_i in IDLE (depth 0): mret_ack_o pulses next cycle with no RESTORE.
  - Async reset mid-stacking returns to IDLE, empties the stack, and issues no ack.

Optional Feature:
- Macro: RT_IBEX_HWS_TAIL_CHAIN_EN.
- With the macro, in RUN with mret_id_i && irq_req_i && irq_prio_i > (stack top):
  - skip RESTORE and SAVE; the saved frame is reused;
  - next cycle pulse mret_ack_o, tail_chain_o, and irq_ack_o with the new id;
  - cur_prio <= irq_prio_i; stack and depth unchanged; FSM stays in RUN.
- Without the macro: tail_chain_o is tied to 0 and every mret takes the RESTORE path.

Decomposition:
- Shared package ibex_pkg gets:
  - hws_sched_state_e;
  - existing hw_stacking_mode_t (SAVE/RESTORE) reused;
  - default MaxNest/PrioW constants.
- Sub-module rt_ibex_prio_stack: LIFO of PrioW entries, depth MaxNest, ports push/pop/top/depth/full.

Test Plan:
- Single irq: cur_prio 0, irq prio 2, id 7; hws_done_i 20 cycles later.
  - Required: hws_start_o(SAVE) at +2; irq_ack_id_o=7; ack 1 cycle after done; cur_prio_o=2, depth=1.
- Nesting: in RUN at prio 2, irq prio 5.
  - Required: SAVE, depth 2, cur_prio 5. mret → RESTORE, cur_prio 2, depth 1, mret_ack_o; second mret → depth 0, IDLE.
- No preempt cases:
  - prio-2 irq while cur_prio=2 → no start;
  - with MaxNest=4 reached, prio-7 irq → no start, irq_ack_o stays 0.
- Simultaneous mret and irq (prio 1, stack top 0) with the macro disabled.
  - Required: RESTORE first, then SAVE for the pending irq from IDLE.
- Tail chain with the macro enabled: stack top 0, mret in RUN with irq prio 3 pending.
  - Required: no hws_start_o; mret_ack_o, tail_chain_o and irq_ack_o together; depth unchanged; cur_prio 3.
- Reset asserted during SAVE_WAIT.
  - Required: immediate IDLE, depth 0, all pulses 0; a stale hws_done_i after reset gets no ack.
